mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_STREAK, default 4, max consecutive data-port grants while fetch is pending.
REQ-002 Parameter: UART_ADDR, default 32'h10000000, simulation UART byte address.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: i_req_valid  in  1  fetch request (always read, word).
REQ-006 Port: i_req_addr  in  32  fetch byte address.
REQ-007 Port: i_req_ready  out  1  fetch request accepted this cycle.
REQ-008 Port: i_resp_valid  out  1  fetch data valid, one-cycle pulse.
REQ-009 Port: i_resp_data  out  32  fetch data.
REQ-010 Port: d_req_valid  in  1  data request.
REQ-011 Port: d_req_we  in  1  1=store, 0=load.
REQ-012 Port: d_req_addr / d_req_wdata  in  32 / 32  data address / store data.
REQ-013 Port: d_req_size  in  3  u_b_h_w code: bit1 word, bit0 half, neither byte, bit2 unsigned.
REQ-014 Port: d_req_ready  out  1  data request accepted this cycle.
REQ-015 Port: d_resp_valid / d_resp_data  out  1 / 32  load or store completion pulse / load data (0 for stores).
REQ-016 Port: ram_addr, ram_din  out  32  shared RAM address / write data.
REQ-017 Port: ram_we  out  1  RAM write enable (RAM writes on negedge of clk).
REQ-018 Port: ram_size  out  3  RAM u_b_h_w code.
REQ-019 Port: ram_dout  in  32  RAM combinational read data.
REQ-020 Port: uart_busy  out  1  store to UART_ADDR granted in previous cycle.

Function
REQ-021 Exactly one request SHALL be granted per cycle at most; grant is combinational: req_ready of the winner high in the same cycle as its valid.
REQ-022 Arbitration: data port wins when both valid, unless streak == MAX_STREAK, in which case fetch wins.
REQ-023 streak SHALL increment on each data grant while i_req_valid is high, saturate at MAX_STREAK, and clear on any fetch grant or any cycle with i_req_valid low.
REQ-024 In the grant cycle, ram_addr/ram_size/ram_din/ram_we SHALL carry the winner's fields; fetch drives ram_size=3'b010, ram_we=0.
REQ-025 Idle cycle (no grant): ram_we=0, ram_addr=0, ram_size=3'b010, ram_din=0.
REQ-026 Response latency exactly 1: resp_valid high in the cycle after grant, resp_data = ram_dout sampled at the grant-cycle posedge.
REQ-027 Each port has one outstanding request; arbiter SHALL not deassert ready based on response state (requester obligation).
REQ-028 Store to UART_ADDR SHALL be forwarded with ram_we=1 (RAM discards it) and SHALL set uart_busy for exactly the next cycle.
REQ-029 Back-to-back grants to the same port on consecutive cycles SHALL be supported (throughput 1/cycle).
REQ-030 No request valid when streak saturated but i_req_valid low: streak clears, data granted.

Reset
REQ-031 While rst high: all ready, resp_valid, ram_we, uart_busy SHALL be 0 combinationally; no grant.
REQ-032 On the cycle after reset: streak=0, resp_valid=0, resp_data=0, uart_busy=0.
REQ-033 A request granted in the cycle before rst asserts SHALL have its response suppressed.

Structure
REQ-034 Shared package: u_b_h_w encodings (SIZE_B=000, SIZE_H=001, SIZE_W=010, SIZE_BU=100, SIZE_HU=101) and UART_ADDR default.
REQ-035 One sub-module natural: mem_arb_fair (streak counter + winner select); datapath muxing and response registers in mem_arbiter.

Verification
REQ-036 Fetch only, addr 0x10 word 0xDEADBEEF preloaded -> i_req_ready same cycle, i_resp_valid next cycle, data 0xDEADBEEF.
REQ-037 Both ports valid continuously, MAX_STREAK=4 -> grant pattern D,D,D,D,I repeating; no response lost.
REQ-038 Store byte 0xA5 to 0x20, then load size 000 from 0x20 -> d_resp_data 0xFFFFFFA5; size 100 -> 0x000000A5.
REQ-039 Store 0x41 to 0x10000000 -> ram_we=1 that cycle, uart_busy=1 next cycle only, d_resp_valid=1, d_resp_data=0.
REQ-040 Grant cycle followed by rst=1 -> no resp_valid, ram_we=0 during rst, streak=0 after release.
REQ-041 Fetch valid, data idle for 10 cycles then data valid -> streak stays 0, first data request granted immediately after fetch drops or loses.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared size encodings, default UART address and RAM request bundle for mem_arbiter.
// No logic; types and constants only.
// Sizes use the u_b_h_w code: bit1 word, bit0 half, neither byte, bit2 unsigned.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_t;

    localparam logic [31:0] UART_ADDR_DEFAULT = 32'h1000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [2:0]  size;
        logic        we;
    } ram_req_t;

endpackage

// File: rtl/mem_arb_fair.sv
// Fetch/data winner select with a bounded data-port streak so fetch cannot starve.
// Latency: grants are combinational in the request cycle.
// Backpressure: the loser simply sees no grant and holds its request.
module mem_arb_fair #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_vld,
    input  logic d_vld,
    output logic i_gnt,
    output logic d_gnt
);

    localparam int SW = ($clog2(MAX_STREAK + 1) > 0) ? $clog2(MAX_STREAK + 1) : 1;

    logic [SW-1:0] streak;
    logic          sat;

    assign sat   = (streak == SW'(MAX_STREAK));
    assign d_gnt = !rst && d_vld && !(i_vld && sat);
    assign i_gnt = !rst && i_vld && !d_gnt;

    // Streak only counts data wins that actually kept a waiting fetch out.
    always_ff @(posedge clk) begin
        if (rst || !i_vld || i_gnt) begin
            streak <= '0;
        end else if (d_gnt && !sat) begin
            streak <= streak + SW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single combinational-read RAM, with UART store detect.
// Latency: grant same cycle as valid; response exactly one cycle after grant.
// Backpressure: ready is the grant; responses cannot be stalled by the requester.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          MAX_STREAK = 4,
    parameter logic [31:0] UART_ADDR  = UART_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    output logic [2:0]  ram_size,
    input  logic [31:0] ram_dout,
    output logic        uart_busy
);

    logic        i_gnt;
    logic        d_gnt;
    logic        uart_hit;
    logic        i_resp_q;
    logic        d_resp_q;
    logic        uart_q;
    logic [31:0] i_data_q;
    logic [31:0] d_data_q;
    ram_req_t    ram_req;

    mem_arb_fair #(
        .MAX_STREAK(MAX_STREAK)
    ) u_fair (
        .clk  (clk),
        .rst  (rst),
        .i_vld(i_req_valid),
        .d_vld(d_req_valid),
        .i_gnt(i_gnt),
        .d_gnt(d_gnt)
    );

    assign i_req_ready = i_gnt;
    assign d_req_ready = d_gnt;

    always_comb begin
        ram_req      = '0;
        ram_req.size = SIZE_W;
        if (d_gnt) begin
            ram_req.addr = d_req_addr;
            ram_req.din  = d_req_wdata;
            ram_req.size = d_req_size;
            ram_req.we   = d_req_we;
        end else if (i_gnt) begin
            ram_req.addr = i_req_addr;
        end
    end

    assign ram_addr = ram_req.addr;
    assign ram_din  = ram_req.din;
    assign ram_size = ram_req.size;
    assign ram_we   = ram_req.we;

    // UART stores still go to the RAM bus; the RAM ignores that address.
    assign uart_hit = d_gnt && d_req_we && (d_req_addr == UART_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            uart_q   <= 1'b0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            i_resp_q <= i_gnt;
            d_resp_q <= d_gnt;
            uart_q   <= uart_hit;
            if (i_gnt) begin
                i_data_q <= ram_dout;
            end
            if (d_gnt) begin
                d_data_q <= d_req_we ? 32'h0 : ram_dout;
            end
        end
    end

    // Gating by rst drops a response whose grant landed just before reset.
    assign i_resp_valid = i_resp_q && !rst;
    assign d_resp_valid = d_resp_q && !rst;
    assign uart_busy    = uart_q && !rst;
    assign i_resp_data  = i_data_q;
    assign d_resp_data  = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random/directed bench for mem_arbiter with a byte-array RAM device.
module tb_mem_arbiter;

    localparam int          MAXS = 4;
    localparam logic [31:0] UART = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [2:0]  d_req_size;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we, uart_busy;
    logic [2:0]  ram_size;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_STREAK(MAXS), .UART_ADDR(UART)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_size(ram_size),
        .ram_dout(ram_dout), .uart_busy(uart_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  size;
    } dreq_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    dreq_t       dq[$];
    logic [31:0] iq[$];
    exp_t        ie[$];
    exp_t        de[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          streak_m = 0;
    logic        exp_uart = 1'b0;
    logic        rst_next = 1'b1;
    logic [31:0] mw [0:63];
    logic [7:0]  mem [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ram_read(input logic [31:0] addr, input logic [2:0] size);
        int a;
        if (addr >= 32'd256) return 32'h0;
        a = int'(addr[7:0]);
        case (size[1:0])
            2'b00:   return size[2] ? {24'h0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
            2'b01:   return size[2] ? {16'h0, mem[a+1], mem[a]} : {{16{mem[a+1][7]}}, mem[a+1], mem[a]};
            default: return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        endcase
    endfunction

    // RAM device: combinational read, write on falling edge, 256 bytes, UART ignored.
    initial begin
        int a;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        ram_dout = 32'h0;
        forever begin
            @(negedge clk or ram_addr or ram_size);
            if (!clk && ram_we && ram_addr < 32'd256) begin
                a = int'(ram_addr[7:0]);
                mem[a] = ram_din[7:0];
                if (ram_size[1:0] != 2'b00) mem[a+1] = ram_din[15:8];
                if (ram_size[1]) begin
                    mem[a+2] = ram_din[23:16];
                    mem[a+3] = ram_din[31:24];
                end
            end
            ram_dout = ram_read(ram_addr, ram_size);
        end
    end

    // Reference memory as words; loads/stores via shifts and masks.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] w;
        logic [31:0] sh;
        w  = mw[addr[7:2]];
        sh = w >> (8 * addr[1:0]);
        if (size[1]) return w;
        if (size[0]) return size[2] ? (sh & 32'hFFFF) : (((sh & 32'hFFFF) ^ 32'h8000) - 32'h8000);
        return size[2] ? (sh & 32'hFF) : (((sh & 32'hFF) ^ 32'h80) - 32'h80);
    endfunction

    function automatic void model_store(input dreq_t r);
        logic [31:0] mask;
        int          sh;
        sh = 8 * int'(r.addr[1:0]);
        if (r.size[1]) mask = 32'hFFFF_FFFF;
        else if (r.size[0]) mask = 32'hFFFF << sh;
        else mask = 32'hFF << sh;
        mw[r.addr[7:2]] = (mw[r.addr[7:2]] & ~mask) | ((r.wdata << sh) & mask);
    endfunction

    function automatic void push_d(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                   input logic [31:0] wdata);
        dreq_t r;
        r.we = we; r.addr = addr; r.size = size; r.wdata = wdata;
        dq.push_back(r);
    endfunction

    function automatic void gen_fetch();
        iq.push_back(32'($urandom_range(0, 63)) << 2);
    endfunction

    function automatic void gen_data();
        dreq_t r;
        int    s;
        r.we = 1'($urandom_range(0, 1));
        s = $urandom_range(0, r.we ? 2 : 4);
        case (s)
            0:       r.size = 3'b000;
            1:       r.size = 3'b001;
            2:       r.size = 3'b010;
            3:       r.size = 3'b100;
            default: r.size = 3'b101;
        endcase
        r.addr = 32'($urandom_range(0, 255));
        if (r.size[1]) r.addr = r.addr & ~32'h3;
        else if (r.size[0]) r.addr = r.addr & ~32'h1;
        r.wdata = $urandom;
        if (r.we && $urandom_range(0, 15) == 0) begin
            r.addr = UART;
            r.size = 3'b000;
        end
        dq.push_back(r);
    endfunction

    task automatic check_cycle();
        logic        eg_i, eg_d;
        dreq_t       r;
        logic [31:0] a;
        exp_t        e;
        eg_d = !rst && d_req_valid && !(i_req_valid && streak_m >= MAXS);
        eg_i = !rst && i_req_valid && !eg_d;
        chk("i_req_ready", 32'(i_req_ready), 32'(eg_i));
        chk("d_req_ready", 32'(d_req_ready), 32'(eg_d));
        chk("uart_busy", 32'(uart_busy), 32'(exp_uart && !rst));
        exp_uart = 1'b0;
        if (eg_d) begin
            r = dq.pop_front();
            chk("ram_addr data", ram_addr, r.addr);
            chk("ram_we data", 32'(ram_we), 32'(r.we));
            chk("ram_size data", 32'(ram_size), 32'(r.size));
            chk("ram_din data", ram_din, r.wdata);
            e.due  = cyc + 1;
            e.data = r.we ? 32'h0 : model_load(r.addr, r.size);
            de.push_back(e);
            if (r.we) begin
                exp_uart = (r.addr == UART);
                if (!exp_uart) model_store(r);
            end
            streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
        end else if (eg_i) begin
            a = iq.pop_front();
            chk("ram_addr fetch", ram_addr, a);
            chk("ram_we fetch", 32'(ram_we), 32'h0);
            chk("ram_size fetch", 32'(ram_size), 32'h2);
            e.due  = cyc + 1;
            e.data = mw[a[7:2]];
            ie.push_back(e);
            streak_m = 0;
        end else begin
            chk("ram_we idle", 32'(ram_we), 32'h0);
            chk("ram_addr idle", ram_addr, 32'h0);
            chk("ram_size idle", 32'(ram_size), 32'h2);
            chk("ram_din idle", ram_din, 32'h0);
        end
        if (!i_req_valid || rst) streak_m = 0;
    endtask

    task automatic tick();
        dreq_t r;
        @(posedge clk);
        #1;
        rst         = rst_next;
        i_req_valid = (iq.size() > 0);
        i_req_addr  = (iq.size() > 0) ? iq[0] : $urandom;
        d_req_valid = (dq.size() > 0);
        if (dq.size() > 0) begin
            r = dq[0];
            d_req_we = r.we; d_req_addr = r.addr; d_req_size = r.size; d_req_wdata = r.wdata;
        end else begin
            d_req_we = 1'($urandom); d_req_addr = $urandom;
            d_req_size = 3'($urandom); d_req_wdata = $urandom;
        end
        #2;
        check_cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (iq.size() + dq.size() + ie.size() + de.size()) > 0; k++) tick();
        tick();
        chk("drain pending", 32'(iq.size() + dq.size() + ie.size() + de.size()), 32'h0);
    endtask

    task automatic mon_port(input string nm, input logic is_d, input logic vld, input logic [31:0] data);
        exp_t e;
        logic due;
        due = 1'b0;
        if (is_d) begin
            if (de.size() > 0 && de[0].due == cyc) begin e = de.pop_front(); due = 1'b1; end
        end else begin
            if (ie.size() > 0 && ie[0].due == cyc) begin e = ie.pop_front(); due = 1'b1; end
        end
        if (rst) begin
            if (due || vld) chk({nm, "_resp_valid in reset"}, 32'(vld), 32'h0);
        end else if (due) begin
            chk({nm, "_resp_valid"}, 32'(vld), 32'h1);
            if (vld) chk({nm, "_resp_data"}, data, e.data);
        end else if (vld) begin
            chk({nm, "_resp_valid unexpected"}, 32'(vld), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon_port("i", 1'b0, i_resp_valid, i_resp_data);
        mon_port("d", 1'b1, d_resp_valid, d_resp_data);
    end

    initial begin
        for (int k = 0; k < 64; k++) mw[k] = 32'h0;
        mw[4] = 32'hDEAD_BEEF;
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0;
        d_req_wdata = 32'h0; d_req_size = 3'b010;

        rst_next = 1'b1;
        iq.push_back(32'h10);
        repeat (3) tick();
        rst_next = 1'b0;
        tick();
        chk("i_resp_data after reset", i_resp_data, 32'h0);
        chk("d_resp_data after reset", d_resp_data, 32'h0);
        drain();

        // Byte store then signed and unsigned byte loads of the same location.
        push_d(1'b1, 32'h20, 3'b000, 32'h1234_56A5);
        push_d(1'b0, 32'h20, 3'b000, 32'h0);
        push_d(1'b0, 32'h20, 3'b100, 32'h0);
        drain();

        push_d(1'b1, UART, 3'b000, 32'h41);
        drain();

        // Both ports saturated: fetch must get every fifth slot.
        for (int k = 0; k < 20; k++) begin gen_fetch(); push_d(1'b0, 32'(k) << 2, 3'b010, 32'h0); end
        drain();

        // Long fetch-only run, then a data request arrives mid-stream.
        for (int k = 0; k < 15; k++) gen_fetch();
        repeat (10) tick();
        push_d(1'b0, 32'h10, 3'b010, 32'h0);
        drain();

        // Grant immediately followed by reset.
        for (int k = 0; k < 3; k++) begin gen_fetch(); gen_data(); end
        tick();
        rst_next = 1'b1;
        repeat (2) tick();
        rst_next = 1'b0;
        drain();

        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 250; k++) begin
                if (iq.size() < 2 && $urandom_range(0, 9) < 3 + 3 * ph) gen_fetch();
                if (dq.size() < 2 && $urandom_range(0, 9) < 3 + 3 * ph) gen_data();
                tick();
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
